// File: rtl/gsense_scan_sequencer.sv
// Wishbone-configured scan sequencer for the nFET sensor array: selects each masked
// channel, waits a settle time, then counts oscillator rising edges over a gate window.
module gsense_scan_sequencer #(
  parameter int unsigned N_CH        = 8,
  parameter int unsigned CNT_W       = 24,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            wbs_cyc_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [31:0]     wbs_adr_i,
  input  logic [31:0]     wbs_dat_i,
  output logic            wbs_ack_o,
  output logic [31:0]     wbs_dat_o,
  input  logic            sens_in,
  output logic [N_CH-1:0] ch_sel_o,
  output logic [N_CH-1:0] ch_oeb_o,
  output logic            irq_o
);

  localparam int unsigned IDX_W = 3;
  localparam logic [3:0] ADR_CTRL   = 4'h0;
  localparam logic [3:0] ADR_STATUS = 4'h1;
  localparam logic [3:0] ADR_CHMASK = 4'h2;
  localparam logic [3:0] ADR_SETTLE = 4'h3;
  localparam logic [3:0] ADR_GATE   = 4'h4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_SETTLE,
    S_GATE,
    S_STORE,
    S_DONE
  } state_e;

  // Bus-side registers
  logic              ack_q;
  logic [31:0]       dat_q;
  logic              cont_q;
  logic              irq_en_q;
  logic              done_q;
  logic              irq_q;
  logic [N_CH-1:0]   chmask_q;
  logic [15:0]       settle_q;
  logic [15:0]       gate_q;

  // Scan engine registers
  state_e            state_q;
  logic [IDX_W-1:0]  ch_idx_q;
  logic [N_CH-1:0]   sh_mask_q;
  logic [15:0]       sh_settle_q;
  logic [15:0]       sh_gate_q;
  logic [15:0]       tmr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [N_CH-1:0]   ch_sel_q;
  logic [CNT_W-1:0]  res_q [N_CH];

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_prev_q;

  logic              wb_req_c;
  logic              wr_en_c;
  logic [3:0]        adr_c;
  logic              start_c;
  logic              abort_c;
  logic              done_clr_c;
  logic              done_d;
  logic              irq_en_d;
  logic              edge_c;
  logic              busy_c;
  logic [31:0]       rdata_c;
  logic [15:0]       gate_len_c;
  logic              sel_found_c;
  logic [IDX_W-1:0]  sel_idx_c;
  logic              unused_ok;

  assign unused_ok = ^{wbs_sel_i, wbs_adr_i, wbs_dat_i};

  assign wb_req_c   = wbs_cyc_i & wbs_stb_i & ~ack_q;
  assign wr_en_c    = wb_req_c & wbs_we_i;
  assign adr_c      = wbs_adr_i[5:2];
  // ABORT in the same CTRL write suppresses START
  assign abort_c    = wr_en_c && (adr_c == ADR_CTRL) && wbs_dat_i[3];
  assign start_c    = wr_en_c && (adr_c == ADR_CTRL) && wbs_dat_i[0] && !wbs_dat_i[3];
  assign done_clr_c = wr_en_c && (adr_c == ADR_STATUS) && wbs_dat_i[1];
  assign irq_en_d   = (wr_en_c && (adr_c == ADR_CTRL)) ? wbs_dat_i[2] : irq_en_q;
  assign done_d     = ((state_q == S_DONE) && !abort_c) | (done_q & ~done_clr_c);
  assign busy_c     = (state_q != S_IDLE);
  assign gate_len_c = (sh_gate_q == 16'd0) ? 16'd1 : sh_gate_q;

  // Oscillator synchronizer and rising-edge detector
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sync_q      <= '0;
      sync_prev_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], sens_in};
      sync_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_c = sync_q[SYNC_STAGES-1] & ~sync_prev_q;

  // Lowest enabled channel at or above the current index
  always_comb begin
    sel_found_c = 1'b0;
    sel_idx_c   = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (!sel_found_c && sh_mask_q[i] && (i >= 32'(ch_idx_q))) begin
        sel_found_c = 1'b1;
        sel_idx_c   = IDX_W'(i);
      end
    end
  end

  // Read mux
  always_comb begin
    rdata_c = '0;
    case (adr_c)
      ADR_CTRL:   rdata_c = {28'd0, 1'b0, irq_en_q, cont_q, 1'b0};
      ADR_STATUS: rdata_c = {25'd0, ch_idx_q, 2'b00, done_q, busy_c};
      ADR_CHMASK: rdata_c = 32'(chmask_q);
      ADR_SETTLE: rdata_c = {16'd0, settle_q};
      ADR_GATE:   rdata_c = {16'd0, gate_q};
      default: begin
        if (adr_c[3] && (32'(adr_c[2:0]) < N_CH)) begin
          rdata_c = 32'(res_q[adr_c[2:0]]);
        end
      end
    endcase
  end

  // Wishbone slave and configuration registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      cont_q   <= 1'b0;
      irq_en_q <= 1'b0;
      chmask_q <= '0;
      settle_q <= '0;
      gate_q   <= '0;
      done_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      ack_q  <= wb_req_c;
      dat_q  <= (wb_req_c && !wbs_we_i) ? rdata_c : '0;
      done_q <= done_d;
      irq_q  <= done_d & irq_en_d;
      if (wr_en_c) begin
        case (adr_c)
          ADR_CTRL: begin
            cont_q   <= wbs_dat_i[1];
            irq_en_q <= wbs_dat_i[2];
          end
          ADR_CHMASK: chmask_q <= wbs_dat_i[N_CH-1:0];
          ADR_SETTLE: settle_q <= wbs_dat_i[15:0];
          ADR_GATE:   gate_q   <= wbs_dat_i[15:0];
          default: ;
        endcase
      end
    end
  end

  // Scan FSM; shadows decouple the running scan from register writes
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= S_IDLE;
      ch_idx_q    <= '0;
      sh_mask_q   <= '0;
      sh_settle_q <= '0;
      sh_gate_q   <= '0;
      tmr_q       <= '0;
      cnt_q       <= '0;
      ch_sel_q    <= '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        res_q[i] <= '0;
      end
    end else if (abort_c) begin
      state_q  <= S_IDLE;
      ch_sel_q <= '0;
      cnt_q    <= '0;
      tmr_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_c) begin
            sh_mask_q   <= chmask_q;
            sh_settle_q <= settle_q;
            sh_gate_q   <= gate_q;
            ch_idx_q    <= '0;
            state_q     <= S_SELECT;
          end
        end
        S_SELECT: begin
          if (sel_found_c) begin
            ch_idx_q <= sel_idx_c;
            ch_sel_q <= N_CH'(1) << sel_idx_c;
            if (sh_settle_q == 16'd0) begin
              tmr_q   <= gate_len_c - 16'd1;
              state_q <= S_GATE;
            end else begin
              tmr_q   <= sh_settle_q - 16'd1;
              state_q <= S_SETTLE;
            end
          end else begin
            state_q <= S_DONE;
          end
        end
        S_SETTLE: begin
          if (tmr_q == 16'd0) begin
            tmr_q   <= gate_len_c - 16'd1;
            state_q <= S_GATE;
          end else begin
            tmr_q <= tmr_q - 16'd1;
          end
        end
        S_GATE: begin
          // Saturating edge count
          if (edge_c && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
          if (tmr_q == 16'd0) begin
            ch_sel_q <= '0;
            state_q  <= S_STORE;
          end else begin
            tmr_q <= tmr_q - 16'd1;
          end
        end
        S_STORE: begin
          res_q[ch_idx_q] <= cnt_q;
          cnt_q           <= '0;
          if (ch_idx_q == IDX_W'(N_CH - 1)) begin
            state_q <= S_DONE;
          end else begin
            ch_idx_q <= ch_idx_q + IDX_W'(1);
            state_q  <= S_SELECT;
          end
        end
        S_DONE: begin
          if (cont_q) begin
            sh_mask_q   <= chmask_q;
            sh_settle_q <= settle_q;
            sh_gate_q   <= gate_q;
            ch_idx_q    <= '0;
            state_q     <= S_SELECT;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign ch_sel_o  = ch_sel_q;
  assign ch_oeb_o  = '0;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_gsense_scan_sequencer.sv
// Self-checking bench for gsense_scan_sequencer: a 24-bit and a 4-bit-counter instance
// share one bus; a sensor model oscillates on whichever channel is selected.
module tb_gsense_scan_sequencer;

  logic        clk;
  logic        rst;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack, ack4;
  logic [31:0] dat, dat4;
  logic        sens_in;
  logic [7:0]  ch_sel, ch_sel4, oeb, oeb4;
  logic        irq, irq4;

  int n_checks = 0;
  int n_fails  = 0;

  int unsigned per_ch [8];
  int unsigned phase;
  int          exp_lo [8];
  int          exp_hi [8];

  logic [7:0]  seq_q [$];
  int          dur_q [$];
  logic [7:0]  prev_sel;
  int          cur_dur;
  int          multihot;

  gsense_scan_sequencer u_dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(dat),
    .sens_in(sens_in), .ch_sel_o(ch_sel), .ch_oeb_o(oeb), .irq_o(irq)
  );

  gsense_scan_sequencer #(.CNT_W(4)) u_dut4 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack4), .wbs_dat_o(dat4),
    .sens_in(sens_in), .ch_sel_o(ch_sel4), .ch_oeb_o(oeb4), .irq_o(irq4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sensor array: the selected channel oscillates with its own period, others read low
  initial begin
    sens_in = 1'b0;
    phase   = 0;
    forever begin
      @(negedge clk);
      phase++;
      sens_in = 1'b0;
      for (int i = 0; i < 8; i++)
        if (ch_sel[i]) sens_in = ((phase % per_ch[i]) < (per_ch[i] / 2));
    end
  end

  // Record select sequence, select durations and any multi-hot cycles
  initial begin
    prev_sel = '0;
    cur_dur  = 0;
    multihot = 0;
    forever begin
      @(negedge clk);
      if (prev_sel != 8'h00 && ch_sel != prev_sel) dur_q.push_back(cur_dur);
      if (ch_sel != 8'h00 && ch_sel != prev_sel) begin
        seq_q.push_back(ch_sel);
        cur_dur = 0;
      end
      if (ch_sel != 8'h00) cur_dur++;
      if ($countones(ch_sel) > 1) multihot++;
      prev_sel = ch_sel;
    end
  end

  function automatic int sat4(input int x);
    return (x > 15) ? 15 : x;
  endfunction

  function automatic logic [7:0] nth_sel(input logic [7:0] mask, input int k);
    int seen = 0;
    logic [7:0] r = '0;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) begin
        if (seen == k) r = 8'(1 << i);
        seen++;
      end
    end
    return r;
  endfunction

  // Reference: a window of G cycles over a period-P oscillator holds G/P or G/P+1 edges
  function automatic void model_scan(input logic [7:0] mask, input int gate);
    int g = (gate == 0) ? 1 : gate;
    for (int c = 0; c < 8; c++) begin
      if (mask[c]) begin
        exp_lo[c] = g / int'(per_ch[c]);
        exp_hi[c] = exp_lo[c] + 1;
      end
    end
  endfunction

  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output logic [31:0] rd4);
    int n = 0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
    do begin
      @(posedge clk); #1; n++;
    end while (!ack && n < 20);
    rd  = dat;
    rd4 = dat4;
    n_checks++;
    if (!ack) begin
      n_fails++;
      $display("FAIL wb_ack adr=%h: no ack after %0d cycles", a, n);
    end
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r, r4;
    wb_xfer(1'b1, a, d, r, r4);
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] rd, output logic [31:0] rd4);
    wb_xfer(1'b0, a, 32'h0, rd, rd4);
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] r, r4;
    int n = 0;
    do begin
      wb_read(32'h04, r, r4);
      n++;
    end while (r[0] && n < 4000);
    n_checks++;
    if (r[0]) begin
      n_fails++;
      $display("FAIL %s_idle_timeout: BUSY still %0d after %0d polls, want 0", tag, r[0], n);
    end
  endtask

  // Runs one scan and checks select order/durations, DONE and every RESULT on both instances
  task automatic run_checked_scan(input string tag, input logic [7:0] mask,
                                  input int settle, input int gate, input logic [31:0] ctrl);
    logic [31:0] r, r4;
    int nexp = $countones(mask);
    int dexp = settle + ((gate == 0) ? 1 : gate);
    wb_write(32'h08, 32'(mask));
    wb_write(32'h0C, 32'(settle));
    wb_write(32'h10, 32'(gate));
    seq_q.delete();
    dur_q.delete();
    wb_write(32'h00, ctrl | 32'h1);
    wait_idle(tag);
    model_scan(mask, gate);
    n_checks++;
    if (seq_q.size() != nexp) begin
      n_fails++;
      $display("FAIL %s_seq_len: got %0d selects, want %0d", tag, seq_q.size(), nexp);
    end else begin
      for (int k = 0; k < nexp; k++) begin
        n_checks++;
        if (seq_q[k] !== nth_sel(mask, k)) begin
          n_fails++;
          $display("FAIL %s_seq%0d: got %h want %h", tag, k, seq_q[k], nth_sel(mask, k));
        end
        n_checks++;
        if (k >= dur_q.size() || dur_q[k] != dexp) begin
          n_fails++;
          $display("FAIL %s_dur%0d: got %0d want %0d", tag, k,
                   (k < dur_q.size()) ? dur_q[k] : -1, dexp);
        end
      end
    end
    wb_read(32'h04, r, r4);
    n_checks++;
    if ((r & 32'h3) !== 32'h2 || (r4 & 32'h3) !== 32'h2) begin
      n_fails++;
      $display("FAIL %s_status: got %h/%h want busy=0 done=1", tag, r, r4);
    end
    for (int c = 0; c < 8; c++) begin
      wb_read(32'h20 + 32'(c * 4), r, r4);
      n_checks++;
      if ($isunknown(r) || int'(r) < exp_lo[c] || int'(r) > exp_hi[c]) begin
        n_fails++;
        $display("FAIL %s_result%0d: got %0d want %0d..%0d", tag, c, r, exp_lo[c], exp_hi[c]);
      end
      n_checks++;
      if ($isunknown(r4) || int'(r4) < sat4(exp_lo[c]) || int'(r4) > sat4(exp_hi[c])) begin
        n_fails++;
        $display("FAIL %s_result4_%0d: got %0d want %0d..%0d", tag, c, r4,
                 sat4(exp_lo[c]), sat4(exp_hi[c]));
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] r, r4;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (ack !== 1'b0 || dat !== 32'h0 || ch_sel !== 8'h0 || oeb !== 8'h0 || irq !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_outputs: ack=%b dat=%h sel=%h oeb=%h irq=%b want all 0",
               ack, dat, ch_sel, oeb, irq);
    end
    for (int a = 0; a < 64; a += 4) begin
      wb_read(32'(a), r, r4);
      n_checks++;
      if (r !== 32'h0 || r4 !== 32'h0) begin
        n_fails++;
        $display("FAIL reset_reg_%h: got %h/%h want 0", a, r, r4);
      end
    end
    for (int c = 0; c < 8; c++) begin
      exp_lo[c] = 0;
      exp_hi[c] = 0;
    end
  endtask

  task automatic test_regs();
    logic [31:0] r, r4;
    logic [31:0] wv [6] = '{32'h5A, 32'hABCD1234, 32'h0000BEEF, 32'h6, 32'hFFFFFFFF, 32'h71};
    logic [31:0] av [6] = '{32'h08, 32'h0C, 32'h10, 32'h00, 32'h14, 32'h04};
    logic [31:0] ev [6] = '{32'h5A, 32'h1234, 32'hBEEF, 32'h6, 32'h0, 32'h0};
    for (int i = 0; i < 6; i++) begin
      wb_write(av[i], wv[i]);
      wb_read(av[i], r, r4);
      n_checks++;
      if (r !== ev[i]) begin
        n_fails++;
        $display("FAIL regs_%h: got %h want %h", av[i], r, ev[i]);
      end
    end
    wb_write(32'h00, 32'h0);
  endtask

  task automatic test_single();
    logic [31:0] r, r4;
    per_ch[0] = 10;
    run_checked_scan("single", 8'h01, 4, 100, 32'h4);
    n_checks++;
    if (irq !== 1'b1 || irq4 !== 1'b1) begin
      n_fails++;
      $display("FAIL single_irq: got %b/%b want 1", irq, irq4);
    end
    wb_write(32'h04, 32'h2);
    n_checks++;
    if (irq !== 1'b0) begin
      n_fails++;
      $display("FAIL single_irq_clear: got %b want 0", irq);
    end
    wb_read(32'h04, r, r4);
    n_checks++;
    if (r[1] !== 1'b0) begin
      n_fails++;
      $display("FAIL single_done_clear: got %b want 0", r[1]);
    end
  endtask

  task automatic test_sparse();
    per_ch[0] = 4; per_ch[2] = 8; per_ch[5] = 16; per_ch[7] = 20;
    run_checked_scan("sparse", 8'hA5, 4, 160, 32'h0);
    n_checks++;
    if (irq !== 1'b0) begin
      n_fails++;
      $display("FAIL sparse_irq_disabled: got %b want 0", irq);
    end
  endtask

  task automatic test_empty();
    logic [31:0] r, r4;
    wb_write(32'h04, 32'h2);
    wb_write(32'h08, 32'h0);
    seq_q.delete();
    wb_write(32'h00, 32'h1);
    repeat (2) @(posedge clk);
    wb_read(32'h04, r, r4);
    n_checks++;
    if ((r & 32'h3) !== 32'h2) begin
      n_fails++;
      $display("FAIL empty_done: status %h want busy=0 done=1", r);
    end
    n_checks++;
    if (seq_q.size() != 0) begin
      n_fails++;
      $display("FAIL empty_select: got %0d selects want 0", seq_q.size());
    end
    for (int c = 0; c < 8; c++) begin
      wb_read(32'h20 + 32'(c * 4), r, r4);
      n_checks++;
      if ($isunknown(r) || int'(r) < exp_lo[c] || int'(r) > exp_hi[c]) begin
        n_fails++;
        $display("FAIL empty_result%0d: got %0d want %0d..%0d", c, r, exp_lo[c], exp_hi[c]);
      end
    end
  endtask

  task automatic test_saturation();
    per_ch[0] = 2;
    run_checked_scan("sat", 8'h01, 4, 100, 32'h0);
    run_checked_scan("gate0", 8'h01, 0, 0, 32'h0);
  endtask

  task automatic test_abort();
    logic [31:0] r, r4;
    int n = 0;
    per_ch[0] = 6; per_ch[1] = 6; per_ch[2] = 6;
    wb_write(32'h04, 32'h2);
    wb_write(32'h08, 32'h07);
    wb_write(32'h0C, 32'd4);
    wb_write(32'h10, 32'd200);
    seq_q.delete();
    wb_write(32'h00, 32'h1);
    while (ch_sel !== 8'h04 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (ch_sel !== 8'h04) begin
      n_fails++;
      $display("FAIL abort_reach_ch2: sel=%h want 04", ch_sel);
    end
    repeat (20) @(negedge clk);
    wb_write(32'h00, 32'h8);
    n_checks++;
    if (ch_sel !== 8'h00) begin
      n_fails++;
      $display("FAIL abort_sel: got %h want 00", ch_sel);
    end
    wb_read(32'h04, r, r4);
    n_checks++;
    if ((r & 32'h3) !== 32'h0) begin
      n_fails++;
      $display("FAIL abort_status: got %h want busy=0 done=0", r);
    end
    model_scan(8'h03, 200);
    for (int c = 0; c < 3; c++) begin
      wb_read(32'h20 + 32'(c * 4), r, r4);
      n_checks++;
      if ($isunknown(r) || int'(r) < exp_lo[c] || int'(r) > exp_hi[c]) begin
        n_fails++;
        $display("FAIL abort_result%0d: got %0d want %0d..%0d", c, r, exp_lo[c], exp_hi[c]);
      end
    end
    seq_q.delete();
    wb_write(32'h00, 32'h9);
    repeat (5) @(posedge clk);
    wb_read(32'h04, r, r4);
    n_checks++;
    if (r[0] !== 1'b0 || seq_q.size() != 0) begin
      n_fails++;
      $display("FAIL abort_wins: busy=%b selects=%0d want 0/0", r[0], seq_q.size());
    end
  endtask

  task automatic test_config_change();
    logic [31:0] r, r4;
    per_ch[0] = 8; per_ch[1] = 8;
    wb_write(32'h08, 32'h03);
    wb_write(32'h0C, 32'd4);
    wb_write(32'h10, 32'd40);
    seq_q.delete();
    dur_q.delete();
    wb_write(32'h00, 32'h1);
    wb_write(32'h08, 32'h80);
    wb_write(32'h10, 32'd10);
    wb_write(32'h00, 32'h1);
    wait_idle("cfg");
    model_scan(8'h03, 40);
    n_checks++;
    if (seq_q.size() != 2 || seq_q[0] !== 8'h01 || seq_q[1] !== 8'h02) begin
      n_fails++;
      $display("FAIL cfg_seq: got %0d selects first=%h, want 01,02", seq_q.size(),
               (seq_q.size() > 0) ? seq_q[0] : 8'h00);
    end
    n_checks++;
    if (dur_q.size() != 2 || dur_q[0] != 44 || dur_q[1] != 44) begin
      n_fails++;
      $display("FAIL cfg_dur: got %0d durations first=%0d, want 44,44", dur_q.size(),
               (dur_q.size() > 0) ? dur_q[0] : -1);
    end
    for (int c = 0; c < 8; c++) begin
      wb_read(32'h20 + 32'(c * 4), r, r4);
      n_checks++;
      if ($isunknown(r) || int'(r) < exp_lo[c] || int'(r) > exp_hi[c]) begin
        n_fails++;
        $display("FAIL cfg_result%0d: got %0d want %0d..%0d", c, r, exp_lo[c], exp_hi[c]);
      end
    end
    wb_read(32'h08, r, r4);
    n_checks++;
    if (r !== 32'h80) begin
      n_fails++;
      $display("FAIL cfg_chmask: got %h want 80", r);
    end
  endtask

  task automatic test_cont();
    logic [31:0] r, r4;
    int n = 0;
    per_ch[0] = 10;
    wb_write(32'h04, 32'h2);
    wb_write(32'h08, 32'h01);
    wb_write(32'h0C, 32'd4);
    wb_write(32'h10, 32'd30);
    seq_q.delete();
    dur_q.delete();
    wb_write(32'h00, 32'h7);
    while (seq_q.size() < 3 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    wb_read(32'h04, r, r4);
    n_checks++;
    if ((r & 32'h3) !== 32'h3 || irq !== 1'b1) begin
      n_fails++;
      $display("FAIL cont_running: status %h irq %b want busy=1 done=1 irq=1", r, irq);
    end
    wb_write(32'h00, 32'h4);
    wait_idle("cont");
    model_scan(8'h01, 30);
    n_checks++;
    if (seq_q.size() < 3) begin
      n_fails++;
      $display("FAIL cont_repeat: got %0d scans want >=3", seq_q.size());
    end
    for (int k = 0; k < seq_q.size(); k++) begin
      n_checks++;
      if (seq_q[k] !== 8'h01 || k >= dur_q.size() || dur_q[k] != 34) begin
        n_fails++;
        $display("FAIL cont_scan%0d: sel %h dur %0d want 01/34", k, seq_q[k],
                 (k < dur_q.size()) ? dur_q[k] : -1);
      end
    end
    wb_read(32'h20, r, r4);
    n_checks++;
    if ($isunknown(r) || int'(r) < exp_lo[0] || int'(r) > exp_hi[0]) begin
      n_fails++;
      $display("FAIL cont_result0: got %0d want %0d..%0d", r, exp_lo[0], exp_hi[0]);
    end
  endtask

  task automatic test_random();
    logic [7:0] mask;
    int settle, gate;
    for (int it = 0; it < 4; it++) begin
      mask = 8'($urandom_range(1, 255));
      for (int c = 0; c < 8; c++) per_ch[c] = 2 * $urandom_range(1, 10);
      settle = $urandom_range(4, 12);
      gate   = $urandom_range(1, 150);
      run_checked_scan($sformatf("rand%0d", it), mask, settle, gate, 32'h0);
    end
  endtask

  task automatic test_reset_midscan();
    logic [31:0] r, r4;
    for (int c = 0; c < 8; c++) per_ch[c] = 6;
    wb_write(32'h08, 32'hFF);
    wb_write(32'h0C, 32'd4);
    wb_write(32'h10, 32'd50);
    wb_write(32'h00, 32'h5);
    repeat (80) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ch_sel !== 8'h00 || irq !== 1'b0 || ack !== 1'b0) begin
      n_fails++;
      $display("FAIL midrst_outputs: sel=%h irq=%b ack=%b want 0", ch_sel, irq, ack);
    end
    rst = 1'b0;
    for (int a = 0; a < 64; a += 4) begin
      wb_read(32'(a), r, r4);
      n_checks++;
      if (r !== 32'h0 || r4 !== 32'h0) begin
        n_fails++;
        $display("FAIL midrst_reg_%h: got %h/%h want 0", a, r, r4);
      end
    end
  endtask

  task automatic test_onehot();
    n_checks++;
    if (multihot != 0 || oeb !== 8'h00 || oeb4 !== 8'h00) begin
      n_fails++;
      $display("FAIL onehot: multihot cycles %0d oeb %h want 0/00", multihot, oeb);
    end
  endtask

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    sel = 4'hF; adr = '0; wdat = '0;
    for (int c = 0; c < 8; c++) per_ch[c] = 10;
    test_reset();
    test_regs();
    test_single();
    test_sparse();
    test_empty();
    test_saturation();
    test_abort();
    test_config_change();
    test_cont();
    test_random();
    test_reset_midscan();
    test_onehot();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
